fetch_buffer: RTL and testbench

- Prefetch queue directly upstream of the pipeline's Fetch/Decode boundary.
- Issues in-order instruction-memory requests with a valid/ready handshake and tolerates variable response latency.
- Buffers returned {PC, instruction} pairs and presents them to the datapath as InstrF/PCF/PCPlus4F.
- Honours StallF, and on a taken branch (PCSrcE/PCTargetE) flushes the queue and discards any responses still in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer_if.sv | 27 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_buffer.sv | 127 ++++++++++++
 tb/tb_fetch_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch prefetch buffer.
// Exports NOP_INSTR, DEFAULT_RESET_PC, fetch_entry_t, occ_width().
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response bundle.
// master = fetch side (drives req), slave = memory side (drives ready/rsp).
interface fetch_buffer_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of T with push/pop/clear, async active-low reset.
// Ports: clk, reset, push, push_data, pop, clear, head, count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  T                              push_data,
   input  logic                          pop,
   input  logic                          clear,
   output T                              head,
   output logic [occ_width(DEPTH)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = occ_width(DEPTH);

   T               mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Pops of an empty FIFO are ignored; a push into a full FIFO
   // is only taken when a pop frees the slot in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Prefetch queue feeding Fetch/Decode: issues imem requests, buffers
// {pc,instr}, flushes on PCSrcE. Ports: clk, reset, imem (if), PCSrcE,
// PCTargetE, StallF, instr_valid, InstrF, PCF, PCPlus4F, occupancy.
// Optional: FETCH_BUF_BYPASS_EN forwards a response straight out when empty.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
   input  logic                          clk,
   input  logic                          reset,
   fetch_buffer_if.master                imem,
   input  logic                          PCSrcE,
   input  logic [31:0]                   PCTargetE,
   input  logic                          StallF,
   output logic                          instr_valid,
   output logic [31:0]                   InstrF,
   output logic [31:0]                   PCF,
   output logic [31:0]                   PCPlus4F,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCW = occ_width(MAX_OUTSTANDING);

   logic [31:0]    fetch_pc;
   logic [OCW-1:0] discard;
   logic [OCW-1:0] outstanding;
   logic [31:0]    pend_pc;
   fetch_entry_t   head_e;
   fetch_entry_t   push_e;
   logic           req_fire;
   logic           rsp_live;
   logic           rsp_take;
   logic           bypass;
   logic           q_push;
   logic           q_pop;

   // Budget counts queued, in-flight and to-be-dropped responses so
   // every accepted request is guaranteed a queue slot.
   assign imem.imem_req_valid = reset && !PCSrcE
      && (int'(occupancy) + int'(outstanding) + int'(discard) < DEPTH)
      && (int'(outstanding) + int'(discard) < MAX_OUTSTANDING);

   assign imem.imem_req_addr = fetch_pc;
   assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

   // A response is live only if it belongs to a tracked request;
   // stale or spurious responses retire nothing from the PC queue.
   assign rsp_live = imem.imem_rsp_valid && (discard == '0)
      && (outstanding != '0);
   assign rsp_take = imem.imem_rsp_valid
      && ((discard != '0) || (outstanding != '0));

`ifdef FETCH_BUF_BYPASS_EN
   assign bypass = rsp_live && !PCSrcE && (occupancy == '0);
`else
   assign bypass = 1'b0;
`endif

   assign q_push = rsp_live && !PCSrcE && !(bypass && !StallF);
   assign q_pop  = (occupancy != '0) && !StallF;

   assign push_e = '{pc: pend_pc, instr: imem.imem_rsp_data};

   fetch_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .T     (logic [31:0])
   ) u_pc_q (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (rsp_live),
      .clear     (PCSrcE),
      .head      (pend_pc),
      .count     (outstanding)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_entry_q (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (push_e),
      .pop       (q_pop),
      .clear     (PCSrcE),
      .head      (head_e),
      .count     (occupancy)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (PCSrcE) begin
         fetch_pc <= PCTargetE;
         discard  <= discard + outstanding - OCW'(rsp_take);
      end else begin
         if (req_fire)
            fetch_pc <= fetch_pc + 32'd4;
         if (imem.imem_rsp_valid && (discard != '0))
            discard <= discard - 1'b1;
      end
   end

   always_comb begin
      instr_valid = 1'b0;
      InstrF      = NOP_INSTR;
      PCF         = fetch_pc;
      if (occupancy != '0) begin
         instr_valid = 1'b1;
         InstrF      = head_e.instr;
         PCF         = head_e.pc;
      end else if (bypass) begin
         instr_valid = 1'b1;
         InstrF      = imem.imem_rsp_data;
         PCF         = pend_pc;
      end
   end

   assign PCPlus4F = PCF + 32'd4;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: vector table plus hand sequences
// for redirect, backpressure and mid-stream reset.
module tb_fetch_buffer;
   import fetch_pkg::*;

   localparam logic [31:0] MEM_TAG = 32'hF000_0000;
   localparam int          DEPTH   = 4;

   typedef struct {
      bit          stall;
      bit          rv;
      logic [31:0] addr;
      bit          iv;
      logic [31:0] pcf;
      int          occ;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallF;
   logic        instr_valid;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic [2:0]  occupancy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] q_addr[$];
   int          q_due[$];
   vec_t        tbl[22];

   fetch_buffer_if bus();

   fetch_buffer #(
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (2),
      .RESET_PC        (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .imem        (bus),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .StallF      (StallF),
      .instr_valid (instr_valid),
      .InstrF      (InstrF),
      .PCF         (PCF),
      .PCPlus4F    (PCPlus4F),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (rst_n && bus.imem_rsp_valid && int'(occupancy) == DEPTH) begin
         miscompares++;
         $display("FAIL overflow: response while full, occ=%0d",
                  occupancy);
      end
   end

   function automatic vec_t v(bit s, bit rv, logic [31:0] a,
                              bit iv, logic [31:0] pc, int o);
      vec_t r;
      r.stall = s; r.rv = rv; r.addr = a;
      r.iv = iv; r.pcf = pc; r.occ = o;
      return r;
   endfunction

   task automatic check_out(string nm, bit rv, logic [31:0] a,
                            bit iv, logic [31:0] pc, int o);
      logic [31:0] ei;
      ei = iv ? (MEM_TAG + pc) : NOP_INSTR;
      vectors++;
      if (bus.imem_req_valid !== rv || bus.imem_req_addr !== a ||
          instr_valid !== iv || PCF !== pc || InstrF !== ei ||
          PCPlus4F !== pc + 32'd4 || int'(occupancy) != o) begin
         miscompares++;
         $display("FAIL %s: got rv=%0b addr=%h iv=%0b pcf=%h ins=%h p4=%h occ=%0d; need rv=%0b addr=%h iv=%0b pcf=%h ins=%h occ=%0d",
                  nm, bus.imem_req_valid, bus.imem_req_addr, instr_valid,
                  PCF, InstrF, PCPlus4F, occupancy,
                  rv, a, iv, pc, ei, o);
      end
   endtask

   task automatic check_val(string nm, logic [31:0] act,
                            logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h need %h", nm, act, exp);
      end
   endtask

   // Memory model: in-order, fixed latency, one response per cycle.
   task automatic tick();
      bit hs;
      int due;
      hs = bus.imem_req_valid && bus.imem_req_ready;
      if (hs) begin
         due = cyc + lat;
         if (q_due.size() > 0 && due <= q_due[$])
            due = q_due[$] + 1;
         q_addr.push_back(bus.imem_req_addr);
         q_due.push_back(due);
      end
      @(posedge clk);
      #1;
      cyc++;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = MEM_TAG + q_addr[0];
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      StallF = 1'b0;
      PCSrcE = 1'b0;
      PCTargetE = 32'h0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'h0;
      q_addr.delete();
      q_due.delete();
      lat = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_hs(string nm, output logic [31:0] a,
                          output bit ok);
      ok = 1'b0;
      a = 32'h0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            a = bus.imem_req_addr;
            ok = 1'b1;
            tick();
            return;
         end
         tick();
      end
      vectors++;
      miscompares++;
      $display("FAIL %s: no request within 30 cycles", nm);
   endtask

   task automatic wait_valid(string nm, output logic [31:0] pc,
                             output logic [31:0] ins, output bit ok);
      ok = 1'b0;
      pc = 32'h0;
      ins = 32'h0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            pc = PCF;
            ins = InstrF;
            ok = 1'b1;
            tick();
            return;
         end
         tick();
      end
      vectors++;
      miscompares++;
      $display("FAIL %s: no valid instr within 30 cycles", nm);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] pc;
      logic [31:0] ins;
      bit ok;

      tbl[0]  = v(0, 1, 32'h00, 0, 32'h00, 0);
      tbl[1]  = v(0, 1, 32'h04, 0, 32'h04, 0);
      tbl[2]  = v(0, 1, 32'h08, 1, 32'h00, 1);
      tbl[3]  = v(0, 1, 32'h0C, 1, 32'h04, 1);
      tbl[4]  = v(0, 1, 32'h10, 1, 32'h08, 1);
      tbl[5]  = v(0, 1, 32'h14, 1, 32'h0C, 1);
      tbl[6]  = v(1, 1, 32'h18, 1, 32'h10, 1);
      tbl[7]  = v(1, 1, 32'h1C, 1, 32'h10, 2);
      tbl[8]  = v(1, 0, 32'h20, 1, 32'h10, 3);
      for (int i = 9; i < 16; i++)
         tbl[i] = v(1, 0, 32'h20, 1, 32'h10, 4);
      tbl[16] = v(0, 0, 32'h20, 1, 32'h10, 4);
      tbl[17] = v(0, 1, 32'h20, 1, 32'h14, 3);
      tbl[18] = v(0, 1, 32'h24, 1, 32'h18, 2);
      tbl[19] = v(0, 1, 32'h28, 1, 32'h1C, 2);
      tbl[20] = v(0, 1, 32'h2C, 1, 32'h20, 2);
      tbl[21] = v(0, 1, 32'h30, 1, 32'h24, 2);

      PCSrcE = 1'b0;
      PCTargetE = 32'h0;
      StallF = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'h0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_out("reset", 0, 32'h0, 0, 32'h0, 0);

      // Streaming, then 10-cycle stall and release.
      apply_reset();
      foreach (tbl[i]) begin
         StallF = tbl[i].stall;
         @(negedge clk);
         check_out($sformatf("vec%0d", i), tbl[i].rv, tbl[i].addr,
                   tbl[i].iv, tbl[i].pcf, tbl[i].occ);
         tick();
      end

      // Redirect with two requests in flight.
      apply_reset();
      lat = 4;
      PCSrcE = 1'b1;
      PCTargetE = 32'h10;
      @(negedge clk);
      check_out("A_redir0", 0, 32'h00, 0, 32'h00, 0);
      tick();
      PCSrcE = 1'b0;
      @(negedge clk);
      check_out("A_req10", 1, 32'h10, 0, 32'h10, 0);
      tick();
      @(negedge clk);
      check_out("A_req14", 1, 32'h14, 0, 32'h14, 0);
      tick();
      PCSrcE = 1'b1;
      PCTargetE = 32'h100;
      @(negedge clk);
      check_out("A_redir", 0, 32'h18, 0, 32'h18, 0);
      tick();
      PCSrcE = 1'b0;
      @(negedge clk);
      check_out("A_drain", 0, 32'h100, 0, 32'h100, 0);
      tick();
      wait_hs("A_hs", a, ok);
      if (ok) check_val("A_first_req", a, 32'h100);
      wait_valid("A_val", pc, ins, ok);
      if (ok) begin
         check_val("A_first_pc", pc, 32'h100);
         check_val("A_first_ins", ins, MEM_TAG + 32'h100);
      end

      // Response and redirect in the same cycle.
      apply_reset();
      @(negedge clk);
      check_out("B_c0", 1, 32'h000, 0, 32'h000, 0);
      tick();
      PCSrcE = 1'b1;
      PCTargetE = 32'h200;
      @(negedge clk);
      check_out("B_redir", 0, 32'h004, 0, 32'h004, 0);
      tick();
      PCSrcE = 1'b0;
      @(negedge clk);
      check_out("B_empty", 1, 32'h200, 0, 32'h200, 0);
      tick();
      @(negedge clk);
      check_out("B_c3", 1, 32'h204, 0, 32'h204, 0);
      tick();
      @(negedge clk);
      check_out("B_first", 1, 32'h208, 1, 32'h200, 1);
      tick();

      // Request backpressure for 5 cycles.
      apply_reset();
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_out($sformatf("C_hold%0d", i), 1, 32'h0, 0, 32'h0, 0);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      check_out("C_accept", 1, 32'h0, 0, 32'h0, 0);
      tick();
      @(negedge clk);
      check_out("C_next", 1, 32'h4, 0, 32'h4, 0);
      tick();
      @(negedge clk);
      check_out("C_out0", 1, 32'h8, 1, 32'h0, 1);
      tick();
      @(negedge clk);
      check_out("C_out4", 1, 32'hC, 1, 32'h4, 1);
      tick();

      // Reset mid-stream with three entries held.
      apply_reset();
      StallF = 1'b1;
      @(negedge clk);
      check_out("D_c0", 1, 32'h0, 0, 32'h0, 0);
      tick();
      @(negedge clk);
      check_out("D_c1", 1, 32'h4, 0, 32'h4, 0);
      tick();
      @(negedge clk);
      check_out("D_c2", 1, 32'h8, 1, 32'h0, 1);
      tick();
      @(negedge clk);
      check_out("D_c3", 1, 32'hC, 1, 32'h0, 2);
      tick();
      @(negedge clk);
      check_out("D_full3", 0, 32'h10, 1, 32'h0, 3);
      #1 rst_n = 1'b0;
      #1;
      check_out("D_rst", 0, 32'h0, 0, 32'h0, 0);
      apply_reset();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check_out("D_rel0", 1, 32'h0, 0, 32'h0, 0);
      tick();
      @(negedge clk);
      check_out("D_rel1", 1, 32'h4, 0, 32'h4, 0);
      tick();
      @(negedge clk);
      check_out("D_rel2", 1, 32'h8, 1, 32'h0, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
